// File: rtl/net_control_sequencer.sv
// net_control_sequencer
//   Initiator end of the processing-unit network control bus. A small program
//   memory is loaded by the host while idle. After start, the sequencer steps
//   through the program and drives the WS-bit control word onto the unit
//   network. The host sees a start/busy/done handshake.
//
//   Instruction format: {op[1:0], arg[AW-1:0], sig[WS-1:0]}
//     op 00 SIG  : drive sig, advance
//     op 01 HOLD : drive sig for arg+1 steps, then advance
//     op 10 JUMP : drive sig, pc <= arg[PAW-1:0]
//     op 11 HALT : drive 0, pulse done, return to IDLE (pc holds)
//
//   Ports
//     clk, rst        clock; asynchronous active-low reset
//     prog_we/addr/data  program write port (honoured only in IDLE)
//     start           begin at pc=0 (sampled only in IDLE)
//     stall           freeze sequencing, bus driven quiet (0)
//     signals_o       registered control word
//     busy            state == RUN
//     done            one-cycle pulse after HALT executes
//     pc_o            current program counter
//     cycles_o        (NET_SEQ_CYCLE_CNT_EN only) saturating count of
//                     non-stalled RUN cycles since the last start
//
//   Optional feature macro: NET_SEQ_CYCLE_CNT_EN
module net_control_sequencer #(
  parameter int WS  = 16,
  parameter int PAW = 6,
  parameter int AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PAW-1:0]    prog_addr,
  input  logic [2+AW+WS-1:0] prog_data,
  input  logic              start,
  input  logic              stall,
  output logic [WS-1:0]     signals_o,
  output logic              busy,
  output logic              done,
  output logic [PAW-1:0]    pc_o
`ifdef NET_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycles_o
`endif
);

  localparam int IW = 2 + AW + WS;

  typedef enum logic [1:0] {
    OP_SIG  = 2'b00,
    OP_HOLD = 2'b01,
    OP_JUMP = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] arg;
    logic [WS-1:0] sig;
  } instr_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [PAW-1:0] pc_q, pc_d;
  logic [AW-1:0]  rpt_q, rpt_d;
  logic [WS-1:0]  sig_q, sig_d;
  logic           done_q, done_d;
  instr_t         cur;

  // Program memory: not reset, so a loaded program survives a reset.
  logic [IW-1:0] mem [2**PAW];

  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) mem[prog_addr] <= prog_data;
  end

  assign cur = instr_t'(mem[pc_q]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rpt_q   <= '0;
      sig_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpt_q   <= rpt_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  // The bus is quiet (0) unless an instruction executes this cycle, so idle,
  // stall and HALT all share the default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpt_d   = rpt_q;
    sig_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          rpt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          case (op_t'(cur.op))
            OP_SIG: begin
              sig_d = cur.sig;
              pc_d  = pc_q + 1'b1;
            end
            OP_HOLD: begin
              sig_d = cur.sig;
              // rpt counts completed repeats; arg=0 degenerates to SIG
              if (rpt_q == cur.arg) begin
                rpt_d = '0;
                pc_d  = pc_q + 1'b1;
              end else begin
                rpt_d = rpt_q + 1'b1;
              end
            end
            OP_JUMP: begin
              sig_d = cur.sig;
              pc_d  = cur.arg[PAW-1:0];
              rpt_d = '0;
            end
            OP_HALT: begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign signals_o = sig_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign pc_o      = pc_q;

`ifdef NET_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (state_q == IDLE && start) begin
      cyc_q <= '0;
    end else if (state_q == RUN && !stall && cyc_q != 32'hFFFF_FFFF) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_net_control_sequencer.sv
// Bench for net_control_sequencer. A shadow copy of the program is unrolled
// into the expected stream of executed steps (HOLD expanded to arg+1 entries,
// JUMPs followed); each non-stalled cycle consumes one entry, stalled cycles
// expect a quiet bus with everything held.
module tb_net_control_sequencer;
  localparam int WS = 16, PAW = 6, AW = 8, DEPTH = 64;
  localparam int IW = 2 + AW + WS;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [PAW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start, stall;
  logic [WS-1:0] signals_o;
  logic          busy, done;
  logic [PAW-1:0] pc_o;
`ifdef NET_SEQ_CYCLE_CNT_EN
  logic [31:0]   cycles_o;
`endif

  net_control_sequencer #(.WS(WS), .PAW(PAW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall),
    .signals_o(signals_o), .busy(busy), .done(done), .pc_o(pc_o)
`ifdef NET_SEQ_CYCLE_CNT_EN
    , .cycles_o(cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  int sh_op [DEPTH];
  int sh_arg[DEPTH];
  int sh_sig[DEPTH];

  int q_sig[$], q_pc[$], q_halt[$];
  bit exp_halts;
  bit stall_plan[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input int op, input int arg, input int sig);
    prog_we   = 1'b1;
    prog_addr = PAW'(addr);
    prog_data = {op[1:0], arg[AW-1:0], sig[WS-1:0]};
    @(negedge clk);
    prog_we   = 1'b0;
    sh_op[addr] = op; sh_arg[addr] = arg; sh_sig[addr] = sig;
  endtask

  task automatic push(input int s, input int p, input int h);
    q_sig.push_back(s); q_pc.push_back(p); q_halt.push_back(h);
  endtask

  // Expand the shadow program into the sequence of executed steps.
  task automatic unroll();
    int pc = 0;
    q_sig.delete(); q_pc.delete(); q_halt.delete();
    exp_halts = 0;
    while (q_sig.size() < 400 && !exp_halts) begin
      case (sh_op[pc])
        0: begin push(sh_sig[pc], pc, 0); pc = (pc + 1) % DEPTH; end
        1: begin
          for (int k = 0; k <= sh_arg[pc]; k++) push(sh_sig[pc], pc, 0);
          pc = (pc + 1) % DEPTH;
        end
        2: begin push(sh_sig[pc], pc, 0); pc = sh_arg[pc] % DEPTH; end
        default: begin push(0, pc, 1); exp_halts = 1; end
      endcase
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) stall_plan[i] = 1'b0;
  endtask

  // Run the loaded program for at most ncyc cycles after start. rnd picks
  // random stalls, otherwise stall_plan. wl_at>=0 attempts a write to addr 0
  // during that cycle, which must be ignored.
  task automatic run_prog(input int ncyc, input bit rnd, input int wl_at);
    int cyc = 0, run_cnt = 0;
    bit halted = 0, st;
    int e_sig, e_pc, e_halt;
    unroll();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_sig", signals_o, 0);
    chk("start_pc", pc_o, 0);
`ifdef NET_SEQ_CYCLE_CNT_EN
    chk("start_cycles", cycles_o, 0);
`endif
    while (!halted && cyc < ncyc) begin
      st = rnd ? ($urandom_range(0, 3) == 0) : stall_plan[cyc];
      stall = st;
      if (cyc == wl_at) begin
        prog_we = 1'b1; prog_addr = '0; prog_data = {2'b11, 8'h00, 16'hDEAD};
      end
      @(negedge clk);
      prog_we = 1'b0;
      cyc++;
      if (st) begin
        chk("stall_sig", signals_o, 0);
        chk("stall_pc", pc_o, q_pc[0]);
        chk("stall_busy", busy, 1);
        chk("stall_done", done, 0);
      end else begin
        run_cnt++;
        e_sig = q_sig.pop_front(); e_pc = q_pc.pop_front(); e_halt = q_halt.pop_front();
        chk("step_sig", signals_o, e_sig);
        chk("step_done", done, e_halt);
        chk("step_busy", busy, e_halt ? 0 : 1);
        chk("step_pc", pc_o, e_halt ? e_pc : q_pc[0]);
        halted = (e_halt != 0);
      end
`ifdef NET_SEQ_CYCLE_CNT_EN
      chk("cycles", cycles_o, run_cnt);
`endif
    end
    stall = 1'b0;
    if (halted) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_sig", signals_o, 0);
      chk("idle_busy", busy, 0);
`ifdef NET_SEQ_CYCLE_CNT_EN
      chk("idle_cycles", cycles_o, run_cnt);
`endif
    end else begin
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_sig", signals_o, 0);
      chk("abort_pc", pc_o, 0);
      rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_sig", signals_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc_o, 0);
    rst = 1'b1;

    for (int a = 0; a < DEPTH; a++) load(a, 3, 0, 0);

    // Linear program
    load(0, 0, 0, 16'h8100); load(1, 0, 0, 16'h0081); load(2, 3, 0, 0);
    clear_plan();
    run_prog(50, 0, -1);
    // Restart of the same program (counter must clear on start)
    run_prog(50, 0, -1);

    // HOLD arg=3
    load(0, 1, 3, 16'h4005); load(1, 3, 0, 0);
    run_prog(50, 0, -1);

    // Same HOLD with a two-cycle stall after the second 4005 cycle
    clear_plan();
    stall_plan[2] = 1'b1; stall_plan[3] = 1'b1;
    run_prog(50, 0, -1);
    clear_plan();

    // JUMP loop with a write attempt to addr 0 while running
    load(0, 0, 0, 16'hA5A5); load(1, 2, 0, 16'h5A5A);
    run_prog(10, 0, 2);

    // Asynchronous reset mid-HOLD
    load(0, 0, 0, 16'h1111); load(1, 1, 3, 16'h4005); load(2, 3, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_sig", signals_o, 16'h4005);
    chk("mid_pc", pc_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_sig", signals_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pc", pc_o, 0);
    @(negedge clk); rst = 1'b1;

    // Random programs with random stalls
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < 12; a++) begin
        int r, op, arg;
        r = $urandom_range(0, 9);
        op = (r < 4) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
        arg = (op == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        load(a, op, arg, $urandom_range(0, 16'hFFFF));
      end
      run_prog(150, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
